dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the 16-bit data memory (4096 x 16, write at clock rising edge, read output updated at falling edge when write enable is low). It sits between the data memory and its two masters, the CPU load/store unit and a DMA/debug port. It selects one request at a time, drives the memory's address, write-data and write-enable lines for exactly one cycle, captures the read result, and returns it with a one-cycle completion pulse.

---
 rtl/dmem_arbiter_if.sv | 17 +
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester channel into the data-memory arbiter: request fields in, grant/done pulses and read data out.
// Latency: n/a (wires only). Backpressure: the requester holds req and its fields until it samples gnt high.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input  gnt, done, rdata);
    modport slave  (input  req, we, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, DMA) arbiter and single-cycle access sequencer for the 4096x16 data memory.
// Latency: gnt one cycle after req is sampled, done one cycle after gnt; one access every 2 cycles back-to-back.
// Backpressure: a losing requester keeps req asserted; req is not sampled while an access is in flight.
module dmem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dma,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q;
    logic              cpu_gnt_q;
    logic              dma_gnt_q;
    logic              cpu_done_q;
    logic              dma_done_q;
    logic              busy_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    // Last granted requester; it also names the owner of the access in flight.
    logic              last_dma_q;
    logic              win_dma_d;

    always_comb begin
        win_dma_d = 1'b0;
        if (dma.req && !cpu.req) begin
            win_dma_d = 1'b1;
        end else if (dma.req && !FIXED_PRI) begin
            win_dma_d = !last_dma_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cpu_gnt_q   <= 1'b0;
            dma_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            last_dma_q  <= 1'b1;
        end else begin
            case (state_q)
                ACCESS: begin
                    cpu_gnt_q  <= 1'b0;
                    dma_gnt_q  <= 1'b0;
                    mem_we_q   <= 1'b0;
                    cpu_done_q <= !last_dma_q;
                    dma_done_q <= last_dma_q;
                    if (!mem_we_q) begin
                        rdata_q <= mem_rdata_i;
                    end
                    state_q    <= RESP;
                end
                default: begin
                    cpu_done_q <= 1'b0;
                    dma_done_q <= 1'b0;
                    if (cpu.req || dma.req) begin
                        state_q     <= ACCESS;
                        busy_q      <= 1'b1;
                        cpu_gnt_q   <= !win_dma_d;
                        dma_gnt_q   <= win_dma_d;
                        last_dma_q  <= win_dma_d;
                        mem_we_q    <= win_dma_d ? dma.we    : cpu.we;
                        mem_addr_q  <= win_dma_d ? dma.addr  : cpu.addr;
                        mem_wdata_q <= win_dma_d ? dma.wdata : cpu.wdata;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign cpu.gnt     = cpu_gnt_q;
    assign dma.gnt     = dma_gnt_q;
    assign cpu.done    = cpu_done_q;
    assign dma.done    = dma_done_q;
    assign cpu.rdata   = rdata_q;
    assign dma.rdata   = rdata_q;
    assign busy_o      = busy_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Two arbiters (index 0 round-robin, index 1 fixed CPU priority), each on its own behavioural 4096x16 memory,
// checked against a transaction-level model of grant order, memory contents and returned read data.
module tb_dmem_arbiter;
    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int CPU = 0;
    localparam int DMA = 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          q_req  [2][2];
    logic          q_we   [2][2];
    logic [AW-1:0] q_addr [2][2];
    logic [DW-1:0] q_wd   [2][2];
    logic          gnt    [2][2];
    logic          done   [2][2];
    logic [DW-1:0] rd     [2];
    logic [DW-1:0] rdd    [2];
    logic          busy   [2];
    logic          mwe    [2];
    logic [AW-1:0] maddr  [2];
    logic [DW-1:0] mwd    [2];

    function automatic logic [DW-1:0] init_val(int a);
        if (a == 1) return 16'h0002;
        if (a == 8) return 16'h0001;
        return DW'(a * 3) ^ 16'h5A5A;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cif ();
        dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();
        logic [DW-1:0] mem [4096];
        logic [DW-1:0] mrd;

        dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(g == 1)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cpu        (cif),
            .dma        (dif),
            .busy_o     (busy[g]),
            .mem_addr_o (maddr[g]),
            .mem_wdata_o(mwd[g]),
            .mem_we_o   (mwe[g]),
            .mem_rdata_i(mrd)
        );

        assign cif.req   = q_req[g][CPU];
        assign cif.we    = q_we[g][CPU];
        assign cif.addr  = q_addr[g][CPU];
        assign cif.wdata = q_wd[g][CPU];
        assign dif.req   = q_req[g][DMA];
        assign dif.we    = q_we[g][DMA];
        assign dif.addr  = q_addr[g][DMA];
        assign dif.wdata = q_wd[g][DMA];
        assign gnt[g][CPU]  = cif.gnt;
        assign gnt[g][DMA]  = dif.gnt;
        assign done[g][CPU] = cif.done;
        assign done[g][DMA] = dif.done;
        assign rd[g]  = cif.rdata;
        assign rdd[g] = dif.rdata;

        initial for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
        always @(posedge clk) if (mwe[g]) mem[maddr[g]] <= mwd[g];
        always @(negedge clk) if (!mwe[g]) mrd <= mem[maddr[g]];
    end

    logic [DW-1:0] ref_mem [2][4096];
    logic          last_dma [2];
    logic [DW-1:0] last_rd [2];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(int d, string t);
        check({t, " busy"},     busy[d], 0);
        check({t, " mem_we"},   mwe[d], 0);
        check({t, " cpu_gnt"},  gnt[d][CPU], 0);
        check({t, " dma_gnt"},  gnt[d][DMA], 0);
        check({t, " cpu_done"}, done[d][CPU], 0);
        check({t, " dma_done"}, done[d][DMA], 0);
        check({t, " rdata"},    rd[d], last_rd[d]);
        check({t, " dma rdata"}, rdd[d], last_rd[d]);
    endtask

    // Checks the done cycle of an access and folds it into the model.
    task automatic done_check(int d, int who, op_t op, string t);
        if (op.we) ref_mem[d][op.a] = op.wd;
        else       last_rd[d] = ref_mem[d][op.a];
        check({t, " done"},       done[d][who], 1);
        check({t, " other done"}, done[d][1-who], 0);
        check({t, " gnt low"},    gnt[d][CPU] | gnt[d][DMA], 0);
        check({t, " we low"},     mwe[d], 0);
        check({t, " busy resp"},  busy[d], 1);
        check({t, " rdata"},      rd[d], last_rd[d]);
    endtask

    task automatic grant_check(int d, int who, op_t op, string t);
        check({t, " gnt"},       gnt[d][who], 1);
        check({t, " other gnt"}, gnt[d][1-who], 0);
        check({t, " busy"},      busy[d], 1);
        check({t, " mem_we"},    mwe[d], op.we);
        check({t, " mem_addr"},  maddr[d], op.a);
        if (op.we) check({t, " mem_wdata"}, mwd[d], op.wd);
        check({t, " no done"},   done[d][CPU] | done[d][DMA], 0);
    endtask

    task automatic present(int d, int who, op_t op);
        q_req[d][who]  = 1'b1;
        q_we[d][who]   = op.we;
        q_addr[d][who] = op.a;
        q_wd[d][who]   = op.wd;
    endtask

    task automatic acc(int d, int who, logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
        op_t   op;
        string t;
        op.we = we; op.a = a; op.wd = wd;
        t = $sformatf("d%0d %s %s @%0h", d, (who == CPU) ? "cpu" : "dma", we ? "wr" : "rd", a);
        present(d, who, op);
        tick();
        grant_check(d, who, op, t);
        last_dma[d]    = (who == DMA);
        q_req[d][who]  = 1'b0;
        q_we[d][who]   = 1'($urandom);
        q_addr[d][who] = AW'($urandom);
        q_wd[d][who]   = DW'($urandom);
        tick();
        done_check(d, who, op, t);
    endtask

    // Both requesters queue work; grants follow the arbitration rule in the model.
    task automatic contend(int d, int nc, int nd);
        op_t   qs [2][$];
        op_t   op;
        int    win;
        string t;
        for (int i = 0; i < nc + nd; i++) begin
            op.we = 1'($urandom);
            op.a  = AW'($urandom_range(0, 31));
            op.wd = DW'($urandom);
            if (i < nc) qs[CPU].push_back(op);
            else        qs[DMA].push_back(op);
        end
        for (int w = 0; w < 2; w++) if (qs[w].size() > 0) present(d, w, qs[w][0]);
        while (qs[CPU].size() + qs[DMA].size() > 0) begin
            if (qs[CPU].size() > 0 && qs[DMA].size() > 0)
                win = ((d == 1) || last_dma[d]) ? CPU : DMA;
            else
                win = (qs[CPU].size() > 0) ? CPU : DMA;
            op = qs[win].pop_front();
            t = $sformatf("d%0d contend %s", d, (win == CPU) ? "cpu" : "dma");
            tick();
            grant_check(d, win, op, t);
            last_dma[d] = (win == DMA);
            if (qs[win].size() > 0) present(d, win, qs[win][0]);
            else                    q_req[d][win] = 1'b0;
            tick();
            done_check(d, win, op, t);
        end
    endtask

    initial begin
        int d, who, gap;
        logic we;
        logic [AW-1:0] a;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4096; i++) ref_mem[k][i] = init_val(i);
            last_dma[k] = 1'b1;
            last_rd[k]  = '0;
            for (int w = 0; w < 2; w++) begin
                q_req[k][w] = 1'b0; q_we[k][w] = 1'b0; q_addr[k][w] = '0; q_wd[k][w] = '0;
            end
        end

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            idle_check(k, $sformatf("d%0d reset", k));
            check($sformatf("d%0d reset mem_addr", k), maddr[k], 0);
            check($sformatf("d%0d reset mem_wdata", k), mwd[k], 0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 2; k++) begin
            acc(k, CPU, 1'b0, 12'h001, 16'h0);
            check($sformatf("d%0d first read", k), rd[k], 16'h0002);
            acc(k, DMA, 1'b1, 12'h0FF, 16'hBEEF);
            acc(k, CPU, 1'b0, 12'h0FF, 16'h0);
            check($sformatf("d%0d readback", k), rd[k], 16'hBEEF);
        end

        contend(0, 3, 3);
        contend(1, 3, 3);
        contend(1, 4, 1);
        contend(0, 1, 4);

        // Reset in the middle of a write: the write must not reach memory.
        present(0, CPU, '{we: 1'b1, a: 12'h008, wd: 16'h1234});
        tick();
        check("rst-mid gnt", gnt[0][CPU], 1);
        check("rst-mid we", mwe[0], 1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            last_dma[k] = 1'b1;
            last_rd[k]  = '0;
        end
        check("rst-mid we dropped", mwe[0], 0);
        check("rst-mid gnt dropped", gnt[0][CPU], 0);
        check("rst-mid busy", busy[0], 0);
        check("rst-mid mem_addr", maddr[0], 0);
        check("rst-mid mem_wdata", mwd[0], 0);
        check("rst-mid rdata", rd[0], 0);
        q_req[0][CPU] = 1'b0;
        tick();
        check("rst-mid no done", done[0][CPU], 0);
        rst_n = 1'b1;
        acc(0, CPU, 1'b0, 12'h008, 16'h0);
        check("rst-mid addr8 kept", rd[0], 16'h0001);

        for (int c = 0; c < 10; c++) begin
            tick();
            for (int k = 0; k < 2; k++) idle_check(k, $sformatf("d%0d idle%0d", k, c));
        end

        for (int n = 0; n < 40; n++) begin
            d   = $urandom_range(0, 1);
            who = $urandom_range(0, 1);
            we  = 1'($urandom);
            a   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            acc(d, who, we, a, DW'($urandom));
            gap = $urandom_range(0, 2);
            for (int c = 0; c < gap; c++) begin
                tick();
                idle_check(d, $sformatf("d%0d gap%0d", d, n));
            end
        end
        for (int n = 0; n < 8; n++) contend(n % 2, $urandom_range(0, 4), $urandom_range(0, 4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
